// File: rtl/muldiv_pkg.sv
// Shared constants, command encodings and FSM state type for the HI/LO
// multiply/divide sequencer.
package muldiv_pkg;
    localparam int DATA_WIDTH = 32;
    localparam int CNT_W      = $clog2(DATA_WIDTH);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_e;

    // MULT/MULTU/DIV/DIVU all have op[2] clear; op[0] clear marks signed.
    function automatic logic is_md(input logic [2:0] op);
        return !op[2];
    endfunction
endpackage

// File: rtl/muldiv_if.sv
// Decode-stage command bus and HI/LO result/status signals of muldiv_ctrl.
interface muldiv_if #(parameter int DW = muldiv_pkg::DATA_WIDTH);
    logic          start;
    logic [2:0]    op;
    logic [DW-1:0] A;
    logic [DW-1:0] B;
    logic          mf_req;
    logic [DW-1:0] HI_out;
    logic [DW-1:0] LO_out;
    logic          busy;
    logic          stall;
    logic          done;
    logic          div_by_zero;

    modport master (output start, op, A, B, mf_req,
                    input  HI_out, LO_out, busy, stall, done, div_by_zero);
    modport slave  (input  start, op, A, B, mf_req,
                    output HI_out, LO_out, busy, stall, done, div_by_zero);
endinterface

// File: rtl/muldiv_step.sv
// One iteration of shift-add multiply or restoring divide on a
// {upper, lower} double-width accumulator.
module muldiv_step
    import muldiv_pkg::*;
(
    input  logic [2*DATA_WIDTH-1:0] acc,
    input  logic [DATA_WIDTH-1:0]   operand,
    input  logic                    is_div,
    output logic [2*DATA_WIDTH-1:0] acc_next
);
    localparam int W = DATA_WIDTH;

    logic [W:0] sum;
    logic [W:0] trial;

    always_comb begin
        sum   = {1'b0, acc[2*W-1:W]} + {1'b0, operand};
        // acc[2W-1:W-1] is the remainder after the left shift, one bit wider
        trial = acc[2*W-1:W-1] - {1'b0, operand};
        if (is_div)
            acc_next = trial[W] ? {acc[2*W-2:0], 1'b0}
                                : {trial[W-1:0], acc[W-2:0], 1'b1};
        else
            acc_next = acc[0] ? {sum, acc[W-1:1]} : {1'b0, acc[2*W-1:1]};
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative MULT/DIV sequencer owning HI/LO: one bit per cycle in CALC,
// sign fix-up and HI/LO write in FIX, stall toward the core while busy.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    muldiv_if.slave  bus
);
    localparam int W = DATA_WIDTH;

    state_e           state, state_nxt;
    logic [2*W-1:0]   acc, acc_step;
    logic [W-1:0]     opnd, a_raw, hi, lo;
    logic [CNT_W-1:0] cnt;
    logic             op_div, op_sgn, neg_res, neg_rem, bz;
    logic             done_q, dbz_q;
    logic             accept_md, write_mt, busy;
    logic             in_sgn, a_neg, b_neg;
    logic [W-1:0]     a_mag, b_mag;
    logic [2*W-1:0]   prod_fix;
    logic [W-1:0]     quo_fix, rem_fix, hi_fix, lo_fix;

    muldiv_step u_step (
        .acc      (acc),
        .operand  (opnd),
        .is_div   (op_div),
        .acc_next (acc_step)
    );

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.start && is_md(bus.op)) state_nxt = CALC;
            CALC:    if (cnt == CNT_W'(W-1))        state_nxt = FIX;
            FIX:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE);
        accept_md = (state == IDLE) && bus.start && is_md(bus.op);
        write_mt  = (state == IDLE) && bus.start &&
                    ((bus.op == OP_MTHI) || (bus.op == OP_MTLO));
    end

    always_comb begin
        in_sgn = !bus.op[0];
        a_neg  = in_sgn && bus.A[W-1];
        b_neg  = in_sgn && bus.B[W-1];
        a_mag  = a_neg ? -bus.A : bus.A;
        b_mag  = b_neg ? -bus.B : bus.B;
    end

    // Divide by zero bypasses sign correction: LO all ones, HI = original A.
    always_comb begin
        prod_fix = (op_sgn && neg_res) ? -acc : acc;
        quo_fix  = (op_sgn && neg_res) ? -acc[W-1:0] : acc[W-1:0];
        rem_fix  = (op_sgn && neg_rem) ? -acc[2*W-1:W] : acc[2*W-1:W];
        if (!op_div) begin
            hi_fix = prod_fix[2*W-1:W];
            lo_fix = prod_fix[W-1:0];
        end else if (bz) begin
            hi_fix = a_raw;
            lo_fix = '1;
        end else begin
            hi_fix = rem_fix;
            lo_fix = quo_fix;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            acc     <= '0;
            opnd    <= '0;
            a_raw   <= '0;
            cnt     <= '0;
            op_div  <= 1'b0;
            op_sgn  <= 1'b0;
            neg_res <= 1'b0;
            neg_rem <= 1'b0;
            bz      <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dbz_q  <= 1'b0;
            if (accept_md) begin
                op_div  <= bus.op[1];
                op_sgn  <= in_sgn;
                neg_res <= a_neg ^ b_neg;
                neg_rem <= a_neg;
                bz      <= (bus.B == '0);
                a_raw   <= bus.A;
                cnt     <= '0;
                acc     <= bus.op[1] ? {{W{1'b0}}, a_mag} : {{W{1'b0}}, b_mag};
                opnd    <= bus.op[1] ? b_mag : a_mag;
            end else if (state == CALC) begin
                acc <= acc_step;
                cnt <= cnt + 1'b1;
            end else if (state == FIX) begin
                hi     <= hi_fix;
                lo     <= lo_fix;
                done_q <= 1'b1;
                dbz_q  <= op_div && bz;
            end
            if (write_mt) begin
                if (bus.op == OP_MTHI) hi <= bus.A;
                else                   lo <= bus.A;
            end
        end
    end

    assign bus.HI_out      = hi;
    assign bus.LO_out      = lo;
    assign bus.busy        = busy;
    assign bus.stall       = busy && (bus.start || bus.mf_req);
    assign bus.done        = done_q;
    assign bus.div_by_zero = dbz_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl: stimulus pushes expected HI/LO results
// from a 64-bit arithmetic model; a monitor pops them on every done pulse.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    muldiv_if bus ();

    muldiv_ctrl dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          due;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [31:0] a,
                                   input logic [31:0] b, input int due);
        exp_t        e;
        longint      sa, sbv;
        logic [63:0] p;
        sa    = $signed(a);
        sbv   = $signed(b);
        e.due = due;
        e.dbz = 1'b0;
        e.hi  = '0;
        e.lo  = '0;
        case (o)
            OP_MULT: begin
                p = sa * sbv;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            OP_MULTU: begin
                p = {32'd0, a} * {32'd0, b};
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 0) begin
                    e.dbz = 1'b1;
                    e.hi  = a;
                    e.lo  = '1;
                end else if (o == OP_DIV) begin
                    p = sa / sbv;
                    e.lo = p[31:0];
                    p = sa % sbv;
                    e.hi = p[31:0];
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
        endcase
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding result.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (bus.done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("done_unexpected", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("hi", bus.HI_out, e.hi);
                    chk("lo", bus.LO_out, e.lo);
                    chk("div_by_zero", bus.div_by_zero, e.dbz);
                    chk("latency", cyc, e.due);
                end
            end else if (bus.div_by_zero !== 1'b0) begin
                chk("dbz_without_done", bus.div_by_zero, 64'd0);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        int   n;
        exp_t e;
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 100) chk("idle_wait", 64'd1, 64'd0);
        bus.start = 1'b1;
        bus.op    = o;
        bus.A     = a;
        bus.B     = b;
        if (is_md(o)) begin
            e = model(o, a, b, cyc + 34);
            exp_q.push_back(e);
            m_hi = e.hi;
            m_lo = e.lo;
        end else if (o == OP_MTHI) begin
            m_hi = a;
        end else if (o == OP_MTLO) begin
            m_lo = a;
        end
        @(negedge CLK);
        bus.start = 1'b0;
        if (is_md(o)) begin
            chk("busy_after_start", bus.busy, 64'd1);
        end else begin
            chk("busy_idle_op", bus.busy, 64'd0);
            chk("hi_idle_op", bus.HI_out, m_hi);
            chk("lo_idle_op", bus.LO_out, m_lo);
        end
    endtask

    initial begin
        int   k, n;
        logic [2:0]  o;
        logic [31:0] a, b;
        exp_t e;
        bus.start  = 1'b0;
        bus.op     = '0;
        bus.A      = '0;
        bus.B      = '0;
        bus.mf_req = 1'b0;

        repeat (3) @(negedge CLK);
        chk("rst_hi", bus.HI_out, 64'd0);
        chk("rst_lo", bus.LO_out, 64'd0);
        chk("rst_busy", bus.busy, 64'd0);
        chk("rst_done", bus.done, 64'd0);
        chk("rst_dbz", bus.div_by_zero, 64'd0);
        RST = 1'b0;
        @(negedge CLK);

        issue(OP_MULT,  32'hFFFFFFFD, 32'd7);
        issue(OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(OP_MULT,  32'hFFFFFFFF, 32'hFFFFFFFF);
        issue(OP_DIV,   32'hFFFFFFF9, 32'd2);
        issue(OP_DIVU,  32'd7,        32'd2);
        issue(OP_DIVU,  32'h00001234, 32'd0);
        issue(OP_DIV,   32'h80000000, 32'hFFFFFFFF);
        issue(OP_DIV,   32'hFFFFFF00, 32'd0);
        issue(OP_MTLO,  32'h0BADF00D, 32'd0);
        issue(3'b110,   32'h12345678, 32'd9);

        // mf_req and a second start arrive mid-operation; both stall until done.
        n = 0;
        while (bus.busy && n < 100) begin
            @(negedge CLK);
            n++;
        end
        k = cyc;
        bus.start = 1'b1;
        bus.op    = OP_MULT;
        bus.A     = 32'h00012345;
        bus.B     = 32'hFFFF0001;
        e = model(OP_MULT, 32'h00012345, 32'hFFFF0001, k + 34);
        exp_q.push_back(e);
        for (int i = 1; i <= 40; i++) begin
            @(negedge CLK);
            chk("stall_busy", bus.busy, (cyc < k + 34) ? 64'd1 : 64'd0);
            chk("stall", bus.stall,
                ((cyc < k + 34) && (bus.start || bus.mf_req)) ? 64'd1 : 64'd0);
            if (cyc == k + 34) begin
                e = model(OP_DIVU, 32'hDEADBEEF, 32'd1000, cyc + 34);
                exp_q.push_back(e);
                m_hi = e.hi;
                m_lo = e.lo;
                break;
            end
            if (i == 1) bus.start = 1'b0;
            if (i == 5) bus.mf_req = 1'b1;
            if (i == 10) begin
                bus.start = 1'b1;
                bus.op    = OP_DIVU;
                bus.A     = 32'hDEADBEEF;
                bus.B     = 32'd1000;
            end
        end
        @(negedge CLK);
        bus.start  = 1'b0;
        bus.mf_req = 1'b0;
        chk("second_accepted", bus.busy, 64'd1);

        // Reset in the middle of a divide abandons it without a done.
        issue(OP_DIV, 32'hFFFFFF9C, 32'd3);
        repeat (9) @(negedge CLK);
        RST = 1'b1;
        exp_q.delete();
        @(negedge CLK);
        chk("midrst_busy", bus.busy, 64'd0);
        chk("midrst_hi", bus.HI_out, 64'd0);
        chk("midrst_lo", bus.LO_out, 64'd0);
        chk("midrst_done", bus.done, 64'd0);
        RST  = 1'b0;
        m_hi = '0;
        m_lo = '0;
        issue(OP_MTHI, 32'hA5A5A5A5, 32'd0);
        repeat (40) @(negedge CLK);

        for (int i = 0; i < 40; i++) begin
            o = 3'($urandom_range(0, 7));
            a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 9))
                0:       b = 32'd0;
                1:       b = 32'hFFFFFFFF;
                2:       b = 32'd1;
                3:       b = $urandom_range(1, 255);
                default: b = $urandom;
            endcase
            issue(o, a, b);
            repeat ($urandom_range(0, 2)) @(negedge CLK);
        end

        n = 0;
        while (exp_q.size() > 0 && n < 200) begin
            @(negedge CLK);
            n++;
        end
        chk("drain", exp_q.size(), 64'd0);
        repeat (2) @(negedge CLK);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
